// File: rtl/uart_pkg.sv
// Shared types for the UART transmitter: parity modes and transmit FSM states.
package uart_pkg;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    EVEN  = 3'd1,
    ODD   = 3'd2,
    MARK  = 3'd3,
    SPACE = 3'd4
  } parity_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } tx_state_t;

  // Codes 5..7 are reserved and behave like NONE, so only 1..4 add a parity bit.
  function automatic logic parity_enabled(input logic [2:0] mode);
    return (mode >= 3'd1) && (mode <= 3'd4);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with show-ahead read data, registered level and full/empty flags.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               rd_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     level
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses a push even if the head leaves in the same cycle.
  always_comb begin
    full    = (level == LVL_W'(DEPTH));
    empty   = (level == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    rd_data = mem[rd_ptr];
  end

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO; framing and baud rate are latched per frame.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 4,
  parameter int DIV_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DIV_W-1:0]             cfg_baud_div,
  input  parity_t                      cfg_parity,
  input  logic                         cfg_stop2,
  input  logic [DATA_BITS-1:0]         s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic                         tx_busy,
  output logic                         txd,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

  localparam int CNT_W = $clog2(DATA_BITS+1);

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] head;
  logic                 start_frame;

  tx_state_t            state;
  logic [DIV_W-1:0]     baud_cnt;
  logic [CNT_W-1:0]     bit_cnt;

  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 par_en;
  logic                 stop2_lat;
  logic [DIV_W-1:0]     bit_div;

  logic [DIV_W-1:0]     div_eff;
  logic                 bit_end;
  logic                 last_stop;

  function automatic logic parity_value(input logic [2:0] mode,
                                        input logic [DATA_BITS-1:0] word);
    case (mode)
      3'd1:    return ^word;
      3'd2:    return ~^word;
      3'd3:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (s_valid),
    .wr_data (s_data),
    .pop     (start_frame),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // A frame starts from IDLE or straight out of the last stop bit, so queued words run back-to-back.
  always_comb begin
    s_ready     = !fifo_full;
    div_eff     = (cfg_baud_div == '0) ? DIV_W'(1) : cfg_baud_div;
    bit_end     = (baud_cnt == '0);
    last_stop   = bit_end && (((state == STOP1) && !stop2_lat) || (state == STOP2));
    start_frame = !fifo_empty && ((state == IDLE) || last_stop);
  end

  // Transmit FSM: baud count-down, bit sequencing and the registered line/busy outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      txd      <= 1'b1;
      tx_busy  <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else if (start_frame) begin
      state    <= START;
      txd      <= 1'b0;
      tx_busy  <= 1'b1;
      baud_cnt <= div_eff;
      bit_cnt  <= '0;
    end else if (state != IDLE) begin
      if (!bit_end) begin
        baud_cnt <= baud_cnt - DIV_W'(1);
      end else begin
        baud_cnt <= bit_div;
        case (state)
          START: begin
            txd     <= shreg[0];
            bit_cnt <= CNT_W'(1);
            state   <= DATA;
          end
          DATA: begin
            if (bit_cnt == CNT_W'(DATA_BITS)) begin
              if (par_en) begin
                txd   <= par_bit;
                state <= PARITY;
              end else begin
                txd   <= 1'b1;
                state <= STOP1;
              end
            end else begin
              txd     <= shreg[0];
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          PARITY: begin
            txd   <= 1'b1;
            state <= STOP1;
          end
          STOP1: begin
            if (stop2_lat) begin
              state <= STOP2;
            end else begin
              state   <= IDLE;
              tx_busy <= 1'b0;
            end
          end
          default: begin
            state   <= IDLE;
            tx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

  // Frame registers: word and framing captured at frame start, word shifted out LSB first.
  always_ff @(posedge clk) begin
    if (start_frame) begin
      shreg     <= head;
      par_bit   <= parity_value(cfg_parity, head);
      par_en    <= parity_enabled(cfg_parity);
      stop2_lat <= cfg_stop2;
      bit_div   <= div_eff;
    end else if (bit_end && ((state == START) || (state == DATA))) begin
      shreg <= shreg >> 1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: table-driven single frames plus multi-frame sequences.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst;

  logic [15:0] cfg_baud_div;
  parity_t     cfg_parity;
  logic        cfg_stop2;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        tx_busy;
  logic        txd;
  logic [2:0]  fifo_level;

  logic [15:0] d7_div;
  parity_t     d7_par;
  logic        d7_stop2;
  logic [6:0]  d7_data;
  logic        d7_valid;
  logic        d7_ready;
  logic        d7_busy;
  logic        d7_txd;
  logic [2:0]  d7_level;

  int   n_tests = 0;
  int   n_fail  = 0;
  bit   use7    = 1'b0;
  logic tx_log   [0:299];
  logic busy_log [0:299];

  typedef struct {
    logic [7:0]  data;
    logic [15:0] div;
    parity_t     par;
    bit          stop2;
    bit          has_par;
    bit          exp_par;
    int          per;
    int          len;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_BITS(8), .DEPTH(4), .DIV_W(16)) dut (
    .clk (clk), .rst (rst), .cfg_baud_div (cfg_baud_div), .cfg_parity (cfg_parity),
    .cfg_stop2 (cfg_stop2), .s_data (s_data), .s_valid (s_valid), .s_ready (s_ready),
    .tx_busy (tx_busy), .txd (txd), .fifo_level (fifo_level)
  );

  uart_tx_fifo #(.DATA_BITS(7), .DEPTH(4), .DIV_W(16)) dut7 (
    .clk (clk), .rst (rst), .cfg_baud_div (d7_div), .cfg_parity (d7_par),
    .cfg_stop2 (d7_stop2), .s_data (d7_data), .s_valid (d7_valid), .s_ready (d7_ready),
    .tx_busy (d7_busy), .txd (d7_txd), .fifo_level (d7_level)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic sample(input int idx);
    tx_log[idx]   = use7 ? d7_txd  : txd;
    busy_log[idx] = use7 ? d7_busy : tx_busy;
  endtask

  task automatic build_frame(input logic [8:0] d, input int nd, input bit has_par,
                             input bit par, input bit stop2,
                             output logic [15:0] bits, output int n);
    int k;
    bits = '0;
    bits[0] = 1'b0;
    for (int i = 0; i < nd; i++) bits[1+i] = d[i];
    k = 1 + nd;
    if (has_par) begin
      bits[k] = par;
      k++;
    end
    bits[k] = 1'b1;
    k++;
    if (stop2) begin
      bits[k] = 1'b1;
      k++;
    end
    n = k;
  endtask

  task automatic check_frame(input string name, input int base, input int per,
                             input logic [15:0] bits, input int n);
    logic bad;
    logic seen;
    for (int k = 0; k < n; k++) begin
      bad  = 1'b0;
      seen = bits[k];
      for (int c = 0; c < per; c++) begin
        if (tx_log[base + k*per + c] !== bits[k]) begin
          bad  = 1'b1;
          seen = tx_log[base + k*per + c];
        end
      end
      n_tests++;
      if (bad) begin
        n_fail++;
        $display("FAIL %s bit %0d: got %b, expected %b", name, k, seen, bits[k]);
      end
    end
  endtask

  task automatic count_busy(input int first, input int last, output int cnt);
    cnt = 0;
    for (int i = first; i <= last; i++) if (busy_log[i] === 1'b1) cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] bits;
    int          nb;
    int          cnt;

    vecs[0] = '{8'hA5, 16'd3, NONE,           1'b0, 1'b0, 1'b0, 4, 40};
    vecs[1] = '{8'h07, 16'd1, EVEN,           1'b1, 1'b1, 1'b1, 2, 24};
    vecs[2] = '{8'h07, 16'd1, ODD,            1'b1, 1'b1, 1'b0, 2, 24};
    vecs[3] = '{8'hFF, 16'd0, SPACE,          1'b0, 1'b1, 1'b0, 2, 22};
    vecs[4] = '{8'h3C, 16'd2, MARK,           1'b1, 1'b1, 1'b1, 3, 36};
    vecs[5] = '{8'h81, 16'd1, parity_t'(3'd6), 1'b0, 1'b0, 1'b0, 2, 20};
    vecs[6] = '{8'h96, 16'd1, EVEN,           1'b0, 1'b1, 1'b0, 2, 22};

    rst = 1'b1;
    cfg_baud_div = 16'd3; cfg_parity = NONE; cfg_stop2 = 1'b0; s_data = '0; s_valid = 1'b0;
    d7_div = 16'd0; d7_par = MARK; d7_stop2 = 1'b0; d7_data = '0; d7_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset txd", txd, 1);
    check("reset tx_busy", tx_busy, 0);
    check("reset fifo_level", fifo_level, 0);
    check("reset s_ready", s_ready, 1);

    // Table of single frames
    for (int v = 0; v < 7; v++) begin
      use7 = 1'b0;
      cfg_baud_div = vecs[v].div;
      cfg_parity   = vecs[v].par;
      cfg_stop2    = vecs[v].stop2;
      s_data       = vecs[v].data;
      s_valid      = 1'b1;
      @(negedge clk);
      s_valid = 1'b0;
      sample(0);
      for (int i = 1; i <= vecs[v].len + 1; i++) begin
        @(negedge clk);
        sample(i);
      end
      build_frame({1'b0, vecs[v].data}, 8, vecs[v].has_par, vecs[v].exp_par, vecs[v].stop2, bits, nb);
      check($sformatf("vec%0d idle before start", v), tx_log[0], 1);
      check_frame($sformatf("vec%0d", v), 1, vecs[v].per, bits, nb);
      count_busy(0, vecs[v].len, cnt);
      check($sformatf("vec%0d busy clocks", v), cnt, vecs[v].len);
      check($sformatf("vec%0d busy after frame", v), busy_log[vecs[v].len + 1], 0);
      check($sformatf("vec%0d txd after frame", v), tx_log[vecs[v].len + 1], 1);
      repeat (3) @(negedge clk);
    end

    // Six words into a 4-deep FIFO: back-pressure and back-to-back frames
    cfg_baud_div = 16'd3; cfg_parity = NONE; cfg_stop2 = 1'b0;
    s_data = 8'h01; s_valid = 1'b1;
    fork
      begin
        int w;
        for (int v = 2; v <= 6; v++) begin
          @(negedge clk);
          s_data = 8'(v);
        end
        check("seq6 level full", fifo_level, 4);
        check("seq6 s_ready low when full", s_ready, 0);
        w = 0;
        while (!s_ready && w < 200) begin
          w++;
          @(negedge clk);
        end
        check("seq6 s_ready wait clocks", w, 37);
        @(negedge clk);
        s_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 250; i++) begin
          @(negedge clk);
          sample(i);
        end
      end
    join
    check("seq6 busy before", busy_log[0], 0);
    count_busy(1, 240, cnt);
    check("seq6 busy clocks", cnt, 240);
    check("seq6 busy after", busy_log[241], 0);
    for (int f = 0; f < 6; f++) begin
      build_frame(9'(f + 1), 8, 1'b0, 1'b0, 1'b0, bits, nb);
      check_frame($sformatf("seq6 frame%0d", f), 1 + 40*f, 4, bits, nb);
    end
    repeat (3) @(negedge clk);

    // Push+pop at level 2, then a push refused while full
    cfg_baud_div = 16'd1;
    s_data = 8'hA1; s_valid = 1'b1;
    fork
      begin
        int w;
        @(negedge clk); s_data = 8'hB2;
        @(negedge clk); s_data = 8'hC3;
        @(negedge clk); s_valid = 1'b0;
        repeat (18) @(negedge clk);
        s_data = 8'hD4; s_valid = 1'b1;
        @(negedge clk);
        check("pushpop level stays 2", fifo_level, 2);
        s_data = 8'hE5;
        @(negedge clk); s_data = 8'hF6;
        @(negedge clk);
        check("fill level 4", fifo_level, 4);
        s_data = 8'h17;
        @(negedge clk);
        check("refused push level", fifo_level, 4);
        check("refused push s_ready", s_ready, 0);
        w = 0;
        while (!s_ready && w < 200) begin
          w++;
          @(negedge clk);
        end
        check("refused push wait clocks", w, 17);
        @(negedge clk);
        s_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 145; i++) begin
          @(negedge clk);
          sample(i);
        end
      end
    join
    count_busy(1, 140, cnt);
    check("seq7 busy clocks", cnt, 140);
    check("seq7 busy after", busy_log[141], 0);
    begin
      logic [7:0] words [7];
      words = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h17};
      for (int f = 0; f < 7; f++) begin
        build_frame({1'b0, words[f]}, 8, 1'b0, 1'b0, 1'b0, bits, nb);
        check_frame($sformatf("seq7 frame%0d", f), 1 + 20*f, 2, bits, nb);
      end
    end
    repeat (3) @(negedge clk);

    // 7-bit MARK frames: div 0 acts as 1, mid-frame div change applies to next frame only
    use7 = 1'b1;
    d7_div = 16'd0; d7_par = MARK; d7_stop2 = 1'b0;
    d7_data = 7'h00; d7_valid = 1'b1;
    fork
      begin
        @(negedge clk); d7_data = 7'h2A;
        @(negedge clk); d7_valid = 1'b0;
        repeat (3) @(negedge clk);
        d7_div = 16'd5;
      end
      begin
        for (int i = 0; i < 90; i++) begin
          @(negedge clk);
          sample(i);
        end
      end
    join
    build_frame(9'h000, 7, 1'b1, 1'b1, 1'b0, bits, nb);
    check_frame("d7 frame0", 1, 2, bits, nb);
    build_frame(9'h02A, 7, 1'b1, 1'b1, 1'b0, bits, nb);
    check_frame("d7 frame1", 21, 6, bits, nb);
    check("d7 busy last clock", busy_log[80], 1);
    check("d7 busy after", busy_log[81], 0);
    use7 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset during data bit 3 of 0x55 with two words queued
    cfg_baud_div = 16'd3; cfg_parity = NONE; cfg_stop2 = 1'b0;
    s_data = 8'h55; s_valid = 1'b1;
    @(negedge clk); s_data = 8'h11;
    @(negedge clk); s_data = 8'h22;
    @(negedge clk); s_valid = 1'b0;
    check("rst-mid queued level", fifo_level, 2);
    repeat (16) @(negedge clk);
    check("rst-mid data bit3 low", txd, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst-mid txd", txd, 1);
    check("rst-mid tx_busy", tx_busy, 0);
    check("rst-mid fifo_level", fifo_level, 0);
    check("rst-mid s_ready", s_ready, 1);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx_busy !== 1'b0 || txd !== 1'b1) cnt++;
    end
    check("rst-mid no further frames", cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
